// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C slave, the I2C master and their
// testbenches.
//   i2c_slave_state_t : slave FSM state encoding
//   ACK / NACK        : SDA level of the acknowledge bit
//   RW_WRITE / RW_READ: value of the R/W bit that follows the address
//   addr_match()      : compares an address byte (addr + R/W) to a 7-bit address
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_slave_state_t;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic addr_match(input logic [7:0] addr_byte,
                                        input logic [6:0] dev_addr);
        return addr_byte[7:1] == dev_addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings the asynchronous SCL/SDA bus lines into the clk domain
// and derives the bus events the slave FSM works from.
//   clk, reset     : system clock, synchronous active-high reset
//   scl_i, sda_i   : raw bus lines
//   sda_o          : synchronized SDA level (aligned with the event outputs)
//   scl_rise_o     : synchronized SCL rising edge (1 clk)
//   scl_fall_o     : synchronized SCL falling edge (1 clk)
//   start_o        : SDA fell while SCL high (1 clk)
//   stop_o         : SDA rose while SCL high (1 clk)
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_d = scl_sync_q[SYNC_STAGES-1];
    assign sda_d = sda_sync_q[SYNC_STAGES-1];

    // Everything resets to 1 so an idle bus produces no spurious events.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_d;
            sda_prev_q <= sda_d;
        end
    end

    assign sda_o      = sda_d;
    assign scl_rise_o = scl_d & ~scl_prev_q;
    assign scl_fall_o = ~scl_d & scl_prev_q;
    // SCL must be high in both samples so an SCL edge never looks like START/STOP.
    assign start_o    = scl_d & scl_prev_q & sda_prev_q & ~sda_d;
    assign stop_o     = scl_d & scl_prev_q & ~sda_prev_q & sda_d;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit addressed I2C slave with a single byte-wide write port and
// a single byte-wide read port.
//   clk, reset  : system clock, synchronous active-high reset
//   i2c_scl     : bus SCL (asynchronous)
//   i2c_sda_in  : bus SDA from the pad (asynchronous)
//   i2c_sda_oe  : 1 pulls SDA low, 0 releases it
//   tx_data     : byte returned on reads, latched when tx_req pulses
//   tx_req      : 1-clk pulse when tx_data is latched
//   rx_data     : last byte written by the master
//   rx_valid    : 1-clk pulse when rx_data is updated
//   busy        : high from an address match until STOP or START
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR    = 7'h55,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (i2c_scl),
        .sda_i     (i2c_sda_in),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start_det),
        .stop_o    (stop_det)
    );

    i2c_slave_state_t state_q;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             oe_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             tx_req_q;
    logic             busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            if (start_det) begin
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                busy_q    <= 1'b0;
            end else if (stop_det) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                oe_q      <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, IGNORE: begin
                        oe_q <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= '0;
                            if (addr_match(shift_q, DEV_ADDR)) begin
                                state_q <= ADDR_ACK;
                                oe_q    <= 1'b1;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                                oe_q    <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (shift_q[0] == RW_READ) begin
                                // The ACK-ending fall already presents the MSB,
                                // so the byte starts with one bit counted.
                                state_q   <= RD_DATA;
                                shift_q   <= {tx_data[6:0], 1'b0};
                                oe_q      <= ~tx_data[7];
                                bit_cnt_q <= 4'd1;
                                tx_req_q  <= 1'b1;
                            end else begin
                                state_q   <= WR_DATA;
                                oe_q      <= 1'b0;
                                bit_cnt_q <= '0;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                rx_data_q  <= {shift_q[6:0], sda_s};
                                rx_valid_q <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            state_q   <= WR_ACK;
                            oe_q      <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            state_q <= WR_DATA;
                            oe_q    <= 1'b0;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) begin
                                state_q   <= RD_ACK;
                                oe_q      <= 1'b0;
                                bit_cnt_q <= '0;
                            end else begin
                                oe_q      <= ~shift_q[7];
                                shift_q   <= {shift_q[6:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_s == ACK) begin
                                // MSB of the new byte goes out on the next fall.
                                state_q   <= RD_DATA;
                                shift_q   <= tx_data;
                                bit_cnt_q <= '0;
                                tx_req_q  <= 1'b1;
                            end else begin
                                state_q <= IGNORE;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        oe_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign i2c_sda_oe = oe_q;
    assign tx_req     = tx_req_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;

endmodule
